// File: rtl/mgmt_pkg.sv
// Shared definitions for the management register bus: initiator state
// encoding and header/address geometry.
package mgmt_pkg;

   localparam int MGMT_RW_BIT    = 15;
   localparam int MGMT_ADDR_BITS = 15;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_HI,
      ADDR_LO,
      WRITE,
      RD_ISSUE,
      RD_WAIT,
      RD_HOLD
   } mgmt_init_state_t;

   // Register addresses live in a 15-bit space that wraps at the top.
   function automatic logic [MGMT_ADDR_BITS-1:0] mgmt_addr_inc(
      input logic [MGMT_ADDR_BITS-1:0] a
   );
      return a + 1'b1;
   endfunction

endpackage

// File: rtl/mgmt_bus_initiator.sv
// Byte-stream to register-bus bridge: 16-bit header, then auto-incrementing
// writes, or reads prefetched one byte ahead of the upstream consumer.
//
//   state    | meaning
//   IDLE     | no transaction
//   ADDR_HI  | waiting for header byte 0 {rw, addr[14:8]}
//   ADDR_LO  | waiting for header byte 1 addr[7:0]
//   WRITE    | each rx byte becomes a register write
//   RD_ISSUE | rd_en asserted for the current address
//   RD_WAIT  | waiting for rd_valid or the timeout counter
//   RD_HOLD  | read byte presented on tx, waiting for consume
module mgmt_bus_initiator
   import mgmt_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        stop,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   output logic        rd_en,
   output logic [15:0] rd_addr,
   input  logic        rd_valid,
   input  logic [7:0]  rd_data,
   output logic        wr_en,
   output logic [15:0] wr_addr,
   output logic [7:0]  wr_data,
   output logic        busy,
   output logic        timeout_err
);

   localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);

   mgmt_init_state_t state, state_nxt;

   logic                      rw;
   logic [MGMT_ADDR_BITS-1:0] addr;
   logic [15:0]               tmo_cnt;
   logic [15:0]               drop_cnt;
   logic                      drop;

   logic abort, rd_take, rd_expire, rd_pending, tx_take;

   assign abort      = start | stop;
   assign rd_take    = (state == RD_WAIT) && rd_valid && !drop;
   assign rd_expire  = (state == RD_WAIT) && !rd_take && (tmo_cnt == 16'd1);
   assign rd_pending = (state == RD_ISSUE) || ((state == RD_WAIT) && !rd_take);
   assign tx_take    = (state == RD_HOLD) && tx_valid && tx_ready;

   assign busy    = (state != IDLE);
   assign rd_en   = (state == RD_ISSUE);
   assign rd_addr = rd_en ? {1'b0, addr} : 16'h0000;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = ADDR_HI;
      end else if (stop) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:     state_nxt = IDLE;
            ADDR_HI:  if (rx_valid) state_nxt = ADDR_LO;
            ADDR_LO:  if (rx_valid) state_nxt = rw ? RD_ISSUE : WRITE;
            WRITE:    state_nxt = WRITE;
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  if (rd_take || rd_expire) state_nxt = RD_HOLD;
            RD_HOLD:  if (tx_take) state_nxt = RD_ISSUE;
            default:  state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rw          <= 1'b0;
         addr        <= '0;
         tmo_cnt     <= '0;
         tx_valid    <= 1'b0;
         tx_data     <= 8'h00;
         wr_en       <= 1'b0;
         wr_addr     <= 16'h0000;
         wr_data     <= 8'h00;
         timeout_err <= 1'b0;
      end else begin
         wr_en       <= 1'b0;
         timeout_err <= 1'b0;
         if (abort) begin
            tx_valid <= 1'b0;
         end else begin
            case (state)
               ADDR_HI: if (rx_valid) begin
                  rw         <= rx_data[MGMT_RW_BIT-8];
                  addr[14:8] <= rx_data[6:0];
               end
               ADDR_LO: if (rx_valid) addr[7:0] <= rx_data;
               WRITE: if (rx_valid) begin
                  wr_en   <= 1'b1;
                  wr_addr <= {1'b0, addr};
                  wr_data <= rx_data;
                  addr    <= mgmt_addr_inc(addr);
               end
               RD_ISSUE: tmo_cnt <= TMO_LOAD;
               RD_WAIT: begin
                  if (rd_take) begin
                     tx_valid <= 1'b1;
                     tx_data  <= rd_data;
                  end else if (rd_expire) begin
                     tx_valid    <= 1'b1;
                     tx_data     <= 8'h00;
                     timeout_err <= 1'b1;
                  end else begin
                     tmo_cnt <= tmo_cnt - 16'd1;
                  end
               end
               RD_HOLD: if (tx_take) begin
                  tx_valid <= 1'b0;
                  addr     <= mgmt_addr_inc(addr);
               end
               default: ;
            endcase
         end
      end
   end

   // An abandoned read may still answer later; swallow that one response.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop     <= 1'b0;
         drop_cnt <= '0;
      end else if (abort && rd_pending) begin
         drop     <= 1'b1;
         drop_cnt <= TMO_LOAD;
      end else if (drop) begin
         if (rd_valid || drop_cnt == 16'd1) drop <= 1'b0;
         else                               drop_cnt <= drop_cnt - 16'd1;
      end
   end

endmodule

// File: tb/tb_mgmt_bus_initiator.sv
// Scoreboard bench for mgmt_bus_initiator: stimulus pushes expected bus
// events into queues; negedge monitors pop and compare as the DUT emits them.
module tb_mgmt_bus_initiator;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        tx_ready = 1'b0;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        rd_en;
   logic [15:0] rd_addr;
   logic        rd_valid = 1'b0;
   logic [7:0]  rd_data = 8'h00;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [7:0]  wr_data;
   logic        busy;
   logic        timeout_err;

   mgmt_bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [14:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_exp_t;

   typedef struct {
      int         due;
      logic [7:0] data;
   } resp_t;

   wr_exp_t     wr_q[$];
   logic [14:0] rd_q[$];
   logic [7:0]  tx_q[$];
   int          tmo_q[$];
   resp_t       resp_q[$];
   logic [7:0]  wdata_q[$];

   int resp_lat = 2;
   bit resp_silent = 1'b0;

   // Register contents seen by the responder: a fixed function of address.
   function automatic logic [7:0] ref_byte(input logic [14:0] a);
      return a[7:0] ^ {1'b0, a[14:8]} ^ 8'h5A;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: DUT event with no expected entry (cycle %0d)", name, cyc);
   endtask

   // Register responder: answers each rd_en after resp_lat cycles.
   initial begin
      resp_t r;
      forever begin
         @(posedge clk);
         #1;
         rd_valid = 1'b0;
         rd_data  = 8'($urandom);
         if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
            rd_valid = 1'b1;
            rd_data  = resp_q[0].data;
            void'(resp_q.pop_front());
         end
         if (rd_en === 1'b1 && !resp_silent) begin
            r.due  = cyc + resp_lat;
            r.data = ref_byte(rd_addr[14:0]);
            resp_q.push_back(r);
         end
      end
   end

   wr_exp_t we;
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (wr_q.size() == 0) unexpected("wr_en");
         else begin
            we = wr_q.pop_front();
            check("wr_addr", 64'(wr_addr), 64'({1'b0, we.addr}));
            check("wr_data", 64'(wr_data), 64'(we.data));
            check("wr_cycle", 64'(cyc), 64'(we.cyc));
         end
      end
      if (rd_en === 1'b1) begin
         if (rd_q.size() == 0) unexpected("rd_en");
         else check("rd_addr", 64'(rd_addr), 64'({1'b0, rd_q.pop_front()}));
      end
      if (rd_en === 1'b1 || wr_en === 1'b1)
         check("rd_wr_exclusive", 64'(rd_en & wr_en), 64'd0);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (tx_q.size() == 0) unexpected("tx_consume");
         else check("tx_data", 64'(tx_data), 64'(tx_q.pop_front()));
      end
      if (timeout_err === 1'b1) begin
         if (tmo_q.size() == 0) unexpected("timeout_err");
         else check("timeout_cycle", 64'(cyc), 64'(tmo_q.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1; tick(); stop = 1'b0;
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
   endtask

   task automatic wr_txn(input logic [14:0] a, input int n, input int end_mode, input bit gaps);
      wr_exp_t e;
      logic [7:0] d;
      pulse_start();
      check("busy_after_start", 64'(busy), 64'd1);
      send({1'b0, a[14:8]});
      send(a[7:0]);
      for (int i = 0; i < n; i++) begin
         d = (wdata_q.size() > 0) ? wdata_q.pop_front() : 8'($urandom);
         e.addr = a + 15'(i);
         e.data = d;
         e.cyc  = cyc + 1;
         wr_q.push_back(e);
         send(d);
         if (gaps && $urandom_range(0, 2) == 0) tick();
      end
      case (end_mode)
         0: pulse_stop();
         1: ;
         default: begin
            start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
         end
      endcase
   endtask

   task automatic rd_txn(input logic [14:0] a, input int n, input int lat);
      int got;
      int g;
      resp_lat    = lat;
      resp_silent = 1'b0;
      for (int i = 0; i <= n; i++) rd_q.push_back(a + 15'(i));
      for (int i = 0; i < n; i++)  tx_q.push_back(ref_byte(a + 15'(i)));
      pulse_start();
      send({1'b1, a[14:8]});
      send(a[7:0]);
      got = 0;
      g = 0;
      while (got < n && g < 500) begin
         tx_ready = 1'($urandom_range(0, 1));
         if (tx_valid && tx_ready) got++;
         tick();
         g++;
      end
      tx_ready = 1'b0;
      check("rd_consumed", 64'(got), 64'(n));
      g = 0;
      while (!tx_valid && g < 40) begin tick(); g++; end
      check("prefetch_valid", 64'(tx_valid), 64'd1);
      pulse_stop();
      check("tx_valid_after_stop", 64'(tx_valid), 64'd0);
      idle(2);
   endtask

   initial begin
      logic [14:0] a;
      int g;
      wr_exp_t e;

      repeat (2) tick();
      check("reset_outputs", 64'({tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr,
                                  wr_data, busy, timeout_err}), 64'd0);
      rst = 1'b0;
      idle(2);

      wdata_q.push_back(8'h0A);
      wdata_q.push_back(8'h0B);
      wdata_q.push_back(8'h0C);
      wr_txn(15'h4000, 3, 0, 1'b0);
      idle(2);

      rd_txn(15'h0004, 3, 3);

      wr_txn(15'h7FFF, 2, 0, 1'b0);
      idle(2);

      // Silent responder: read must time out and return 0x00.
      resp_silent = 1'b1;
      a = 15'($urandom_range(0, 32766));
      rd_q.push_back(a);
      tx_q.push_back(8'h00);
      rd_q.push_back(a + 15'd1);
      pulse_start();
      send({1'b1, a[14:8]});
      tmo_q.push_back(cyc + TMO + 2);
      send(a[7:0]);
      g = 0;
      while (!tx_valid && g < 40) begin tick(); g++; end
      check("timeout_tx_valid", 64'(tx_valid), 64'd1);
      check("timeout_tx_data", 64'(tx_data), 64'd0);
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
      pulse_stop();
      idle(TMO + 4);
      resp_silent = 1'b0;

      // Abandon a read in RD_WAIT; its late answer lands in the next read's wait.
      resp_lat = 8;
      a = 15'($urandom_range(0, 16'h7EFF));
      rd_q.push_back(a);
      pulse_start();
      send({1'b1, a[14:8]});
      send(a[7:0]);
      tick();
      pulse_stop();
      check("busy_after_stop", 64'(busy), 64'd0);
      rd_txn(a + 15'h0100, 2, 8);
      idle(TMO + 4);

      for (int it = 0; it < 16; it++) begin
         a = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFD + 15'($urandom_range(0, 2)))
                                         : 15'($urandom);
         if ($urandom_range(0, 1) == 0)
            wr_txn(a, $urandom_range(0, 5), $urandom_range(0, 2), 1'b1);
         else
            rd_txn(a, $urandom_range(1, 4), $urandom_range(1, TMO));
         idle($urandom_range(0, 2));
      end

      // Reset in the middle of a write burst.
      pulse_start();
      send(8'h12);
      send(8'h34);
      for (int i = 0; i < 3; i++) begin
         e.addr = 15'h1234 + 15'(i);
         e.data = 8'(8'hC0 + i);
         e.cyc  = cyc + 1;
         wr_q.push_back(e);
         send(e.data);
      end
      rst = 1'b1;
      rx_valid = 1'b1;
      rx_data = 8'h55;
      tick();
      rst = 1'b0;
      rx_valid = 1'b0;
      check("post_reset_outputs", 64'({tx_valid, tx_data, rd_en, rd_addr, wr_en, wr_addr,
                                       wr_data, busy, timeout_err}), 64'd0);
      send(8'h66);
      send(8'h77);
      idle(4);

      check("wr_q_drained", 64'(wr_q.size()), 64'd0);
      check("rd_q_drained", 64'(rd_q.size()), 64'd0);
      check("tx_q_drained", 64'(tx_q.size()), 64'd0);
      check("tmo_q_drained", 64'(tmo_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $fatal(1, "watchdog expired");
   end

endmodule
